// File: rtl/dbg_tx_arbiter_if.sv
// Bus bundle between the debug-message producers and the shared UART byte sink.
// Purpose : groups the per-requester byte streams, the single transmit stream
//           and the arbiter status so that they travel as one port.
// Signals : req_valid/req_data/req_last/req_ready  per-requester byte handshake
//           tx_valid/tx_data/tx_ready               byte stream toward the UART
//           grant_id/busy/timeout_err               arbiter status
// Modports: master - producer/UART side (drives requests and tx_ready)
//           slave  - arbiter side
interface dbg_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_id, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/dbg_tx_arbiter.sv
// Shares the single debug UART transmitter among N_REQ message producers.
// Grants are message-atomic and issued round-robin; a grant is revoked when the
// owner leaves its valid low for TIMEOUT consecutive cycles mid-message.
// Ports:
//   clk48  - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - dbg_tx_arbiter_if.slave: requester handshakes, UART byte stream,
//            grant_id / busy / timeout_err status
module dbg_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk48,
  input  logic             rst_n,
  dbg_tx_arbiter_if.slave  bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state_reg, state_next;
  logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [CW-1:0] idle_cnt_reg, idle_cnt_next;
  logic          timeout_err_reg, timeout_err_next;

  logic [7:0]       data_arr [N_REQ];
  logic [N_REQ-1:0] ready_vec;
  logic             owner_valid;
  logic             beat;
  logic             found;
  logic [GW-1:0]    winner;
  logic [GW-1:0]    ptr_after_grant;

  // Per-lane byte view and ready steering (only the owner ever sees ready).
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign data_arr[gi]  = bus.req_data[8*gi +: 8];
      assign ready_vec[gi] = (state_reg == XFER) && (grant_reg == GW'(gi)) &&
                             bus.req_valid[gi] && bus.tx_ready;
    end
  endgenerate

  assign owner_valid     = (state_reg == XFER) && bus.req_valid[grant_reg];
  assign beat            = owner_valid && bus.tx_ready;
  assign ptr_after_grant = (grant_reg == LAST_IDX) ? '0 : grant_reg + 1'b1;

  // Round-robin scan: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [GW-1:0] idx;
    found  = 1'b0;
    winner = rr_ptr_reg;
    idx    = rr_ptr_reg;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    grant_next       = grant_reg;
    idle_cnt_next    = idle_cnt_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next    = XFER;
          grant_next    = winner;
          idle_cnt_next = '0;
        end
      end
      XFER: begin
        if (beat) begin
          idle_cnt_next = '0;
          if (bus.req_last[grant_reg]) begin
            state_next  = IDLE;
            rr_ptr_next = ptr_after_grant;
          end
        end else if (!owner_valid) begin
          // Backpressure with valid high is not idle; only a silent owner counts.
          if (idle_cnt_reg + 1'b1 == TO_VAL) begin
            state_next       = IDLE;
            rr_ptr_next      = ptr_after_grant;
            idle_cnt_next    = '0;
            timeout_err_next = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      grant_reg       <= '0;
      idle_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      grant_reg       <= grant_next;
      idle_cnt_reg    <= idle_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign bus.tx_valid    = owner_valid;
  assign bus.tx_data     = owner_valid ? data_arr[grant_reg] : 8'h00;
  assign bus.req_ready   = ready_vec;
  assign bus.grant_id    = grant_reg;
  assign bus.busy        = (state_reg == XFER);
  assign bus.timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_dbg_tx_arbiter.sv
// Self-checking bench for dbg_tx_arbiter (N_REQ=4, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Table rows cover single-cycle behaviour; hand sequences cover
// backpressure, timeout and mid-message reset.
module tb_dbg_tx_arbiter;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 16;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk48 = ~clk48;

  dbg_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  dbg_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic        rstn;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [3:0]  rl;
    logic        txr;
    logic        etv;
    logic [7:0]  etd;
    logic [3:0]  erdy;
    logic        ebusy;
    logic [1:0]  egid;
    logic        eterr;
  } vec_t;

  vec_t vq[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string tag, input logic rstn, input logic [3:0] rv,
                     input logic [31:0] rd, input logic [3:0] rl, input logic txr,
                     input logic etv, input logic [7:0] etd, input logic [3:0] erdy,
                     input logic ebusy, input logic [1:0] egid, input logic eterr);
    vec_t v;
    v.tag = tag; v.rstn = rstn; v.rv = rv; v.rd = rd; v.rl = rl; v.txr = txr;
    v.etv = etv; v.etd = etd; v.erdy = erdy; v.ebusy = ebusy; v.egid = egid; v.eterr = eterr;
    vq.push_back(v);
  endtask

  // Drive one cycle of inputs, then wait for the sampling point.
  task automatic step(input logic rstn, input logic [3:0] rv, input logic [31:0] rd,
                      input logic [3:0] rl, input logic txr);
    @(posedge clk48);
    #1;
    rst_n         = rstn;
    bus.req_valid = rv;
    bus.req_data  = rd;
    bus.req_last  = rl;
    bus.tx_ready  = txr;
    @(negedge clk48);
  endtask

  task automatic chk_all(input string tag, input logic etv, input logic [7:0] etd,
                         input logic [3:0] erdy, input logic ebusy, input logic [1:0] egid,
                         input logic eterr, input logic gid_chk);
    chk({tag, ".tx_valid"},    32'(bus.tx_valid),    32'(etv));
    chk({tag, ".tx_data"},     32'(bus.tx_data),     32'(etd));
    chk({tag, ".req_ready"},   32'(bus.req_ready),   32'(erdy));
    chk({tag, ".busy"},        32'(bus.busy),        32'(ebusy));
    chk({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(eterr));
    if (gid_chk) chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(egid));
    $display("%s: tx_valid=%0b tx_data=%02h req_ready=%04b busy=%0b grant_id=%0d timeout_err=%0b",
             tag, bus.tx_valid, bus.tx_data, bus.req_ready, bus.busy, bus.grant_id, bus.timeout_err);
  endtask

  initial begin
    int idle_cycles;
    bit seen;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;

    // ---- Single-requester message
    add("t1.rst", 0, 4'b0000, 32'h0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t1.c0",  1, 4'b0001, 32'h41, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t1.c1",  1, 4'b0001, 32'h41, 4'b0000, 1, 1, 8'h41, 4'b0001, 1, 0, 0);
    add("t1.c2",  1, 4'b0001, 32'h42, 4'b0000, 1, 1, 8'h42, 4'b0001, 1, 0, 0);
    add("t1.c3",  1, 4'b0001, 32'h43, 4'b0001, 1, 1, 8'h43, 4'b0001, 1, 0, 0);
    add("t1.c4",  1, 4'b0000, 32'h0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    // ---- Round-robin between req0 and req2 (req0 re-requests immediately)
    add("t2.rst", 0, 4'b0000, 32'h0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t2.r1",  1, 4'b0101, 32'h00C0_00A0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t2.r2",  1, 4'b0101, 32'h00C0_00A0, 4'b0000, 1, 1, 8'hA0, 4'b0001, 1, 0, 0);
    add("t2.r3",  1, 4'b0101, 32'h00C0_00A1, 4'b0001, 1, 1, 8'hA1, 4'b0001, 1, 0, 0);
    add("t2.r4",  1, 4'b0101, 32'h00C0_00B0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t2.r5",  1, 4'b0101, 32'h00C0_00B0, 4'b0000, 1, 1, 8'hC0, 4'b0100, 1, 2, 0);
    add("t2.r6",  1, 4'b0101, 32'h00C1_00B0, 4'b0100, 1, 1, 8'hC1, 4'b0100, 1, 2, 0);
    add("t2.r7",  1, 4'b0101, 32'h00D0_00B0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t2.r8",  1, 4'b0101, 32'h00D0_00B0, 4'b0000, 1, 1, 8'hB0, 4'b0001, 1, 0, 0);
    add("t2.r9",  1, 4'b0101, 32'h00D0_00B1, 4'b0001, 1, 1, 8'hB1, 4'b0001, 1, 0, 0);
    add("t2.r10", 1, 4'b0100, 32'h00D0_0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t2.r11", 1, 4'b0100, 32'h00D0_0000, 4'b0000, 1, 1, 8'hD0, 4'b0100, 1, 2, 0);
    add("t2.r12", 1, 4'b0100, 32'h00D1_0000, 4'b0100, 1, 1, 8'hD1, 4'b0100, 1, 2, 0);
    add("t2.r13", 1, 4'b0000, 32'h0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    // ---- Highest index requester, pointer wrap back to 0
    add("t6.rst", 0, 4'b0000, 32'h0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t6.s1",  1, 4'b1000, 32'hE000_0000, 4'b1000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t6.s2",  1, 4'b1000, 32'hE000_0000, 4'b1000, 1, 1, 8'hE0, 4'b1000, 1, 3, 0);
    add("t6.s3",  1, 4'b1000, 32'hF000_0000, 4'b1000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t6.s4",  1, 4'b1000, 32'hF000_0000, 4'b1000, 1, 1, 8'hF0, 4'b1000, 1, 3, 0);
    add("t6.s5",  1, 4'b1001, 32'hF100_0001, 4'b1001, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t6.s6",  1, 4'b1001, 32'hF100_0001, 4'b1001, 1, 1, 8'h01, 4'b0001, 1, 0, 0);
    add("t6.s7",  1, 4'b1000, 32'hF100_0000, 4'b1000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);
    add("t6.s8",  1, 4'b1000, 32'hF100_0000, 4'b1000, 1, 1, 8'hF1, 4'b1000, 1, 3, 0);
    add("t6.s9",  1, 4'b0000, 32'h0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].rstn, vq[i].rv, vq[i].rd, vq[i].rl, vq[i].txr);
      chk_all(vq[i].tag, vq[i].etv, vq[i].etd, vq[i].erdy, vq[i].ebusy, vq[i].egid,
              vq[i].eterr, vq[i].ebusy || !vq[i].rstn);
    end

    // ---- UART backpressure during a req1 message
    step(0, 4'b0000, 32'h0, 4'b0000, 1);
    step(1, 4'b0010, 32'h0000_1100, 4'b0000, 1);
    chk_all("t3.grant", 0, 8'h00, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0010, 32'h0000_1100, 4'b0000, 1);
    chk_all("t3.b0", 1, 8'h11, 4'b0010, 1, 1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 4'b0010, 32'h0000_1200, 4'b0000, 0);
      chk_all($sformatf("t3.hold%0d", i), 1, 8'h12, 4'b0000, 1, 1, 0, 1);
    end
    step(1, 4'b0010, 32'h0000_1200, 4'b0000, 1);
    chk_all("t3.b1", 1, 8'h12, 4'b0010, 1, 1, 0, 1);
    step(1, 4'b0010, 32'h0000_1300, 4'b0010, 1);
    chk_all("t3.b2", 1, 8'h13, 4'b0010, 1, 1, 0, 1);
    step(1, 4'b0000, 32'h0, 4'b0000, 1);
    chk_all("t3.done", 0, 8'h00, 4'b0000, 0, 0, 0, 0);

    // ---- Idle timeout on req1 while req3 waits
    step(0, 4'b0000, 32'h0, 4'b0000, 1);
    step(1, 4'b1010, 32'h3100_2100, 4'b0000, 1);
    chk_all("t4.grant", 0, 8'h00, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b1010, 32'h3100_2100, 4'b0000, 1);
    chk_all("t4.b0", 1, 8'h21, 4'b0010, 1, 1, 0, 1);
    idle_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1, 4'b1000, 32'h3100_0000, 4'b1000, 1);
      if (bus.timeout_err === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) begin
        idle_cycles++;
        chk($sformatf("t4.idle%0d.tx_valid", i), 32'(bus.tx_valid), 32'd0);
      end
    end
    chk("t4.timeout_seen", 32'(seen), 32'd1);
    chk("t4.idle_cycles", 32'(idle_cycles), 32'(TIMEOUT));
    chk("t4.pulse.busy", 32'(bus.busy), 32'd0);
    $display("t4.pulse: timeout_err=%0b busy=%0b idle_cycles=%0d", bus.timeout_err, bus.busy, idle_cycles);
    step(1, 4'b1000, 32'h3100_0000, 4'b1000, 1);
    chk_all("t4.req3", 1, 8'h31, 4'b1000, 1, 3, 0, 1);
    step(1, 4'b0000, 32'h0, 4'b0000, 1);
    chk_all("t4.done", 0, 8'h00, 4'b0000, 0, 0, 0, 0);

    // ---- Reset mid-message; pointer must restart at 0
    step(0, 4'b0000, 32'h0, 4'b0000, 1);
    step(1, 4'b0010, 32'h0000_6000, 4'b0010, 1);
    chk_all("t5.g1", 0, 8'h00, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0010, 32'h0000_6000, 4'b0010, 1);
    chk_all("t5.req1", 1, 8'h60, 4'b0010, 1, 1, 0, 1);
    step(1, 4'b0100, 32'h0051_0000, 4'b0000, 1);
    chk_all("t5.g2", 0, 8'h00, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0100, 32'h0051_0000, 4'b0000, 1);
    chk_all("t5.req2b0", 1, 8'h51, 4'b0100, 1, 2, 0, 1);
    step(0, 4'b0100, 32'h0052_0000, 4'b0000, 1);
    chk_all("t5.rst0", 0, 8'h00, 4'b0000, 0, 0, 0, 1);
    step(0, 4'b0100, 32'h0052_0000, 4'b0000, 1);
    chk_all("t5.rst1", 0, 8'h00, 4'b0000, 0, 0, 0, 1);
    step(1, 4'b0110, 32'h0052_6100, 4'b0110, 1);
    chk_all("t5.arb", 0, 8'h00, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0110, 32'h0052_6100, 4'b0110, 1);
    chk_all("t5.req1again", 1, 8'h61, 4'b0010, 1, 1, 0, 1);
    step(1, 4'b0100, 32'h0052_0000, 4'b0100, 1);
    chk_all("t5.arb2", 0, 8'h00, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0100, 32'h0052_0000, 4'b0100, 1);
    chk_all("t5.req2", 1, 8'h52, 4'b0100, 1, 2, 0, 1);
    step(1, 4'b0000, 32'h0, 4'b0000, 1);
    chk_all("t5.done", 0, 8'h00, 4'b0000, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
